// File: rtl/seven_seg_scan_ctrl_if.sv
// rtl/seven_seg_scan_ctrl_if.sv - Avalon-MM register bus bundle for the 7-segment scan controller
interface seven_seg_scan_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write,
    output writedata,
    output read,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write,
    input  writedata,
    input  read,
    output readdata
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - multiplexed hex 7-segment scan controller, optional SEVSEG_LZ_BLANK_EN leading-zero blanking
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  seven_seg_scan_ctrl_if.slave  bus,
  output logic [6:0]            segs,
  output logic [NUM_DIGITS-1:0] digit_sel
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ON    = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam logic [31:0] DWELL_LAST  = 32'(DWELL_CYCLES - 1);
  localparam logic [31:0] BLANK_LAST  = 32'(BLANK_CYCLES - 1);
  localparam logic [2:0]  IDX_LAST    = 3'(NUM_DIGITS - 1);
  localparam logic [2:0]  ADDR_STATUS = 3'd6;
  localparam logic [2:0]  ADDR_CTRL   = 3'd7;

  state_t                state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [1:0]            ctrl_q, ctrl_d;
  logic [4:0]            digit_q [NUM_DIGITS];
  logic [4:0]            digit_d [NUM_DIGITS];
  logic [6:0]            segs_q, segs_d;
  logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic [31:0]           readdata_q, readdata_d;

  logic       bus_wr;
  logic       bus_rd;
  logic       enable;
  logic       force_blank;
  logic [2:0] idx_next;
  logic [4:0] lit_value;
  logic       lz_suppress;
  logic       unused_wdata;

  assign bus_wr      = bus.chipselect & bus.write;
  assign bus_rd      = bus.chipselect & bus.read;
  assign enable      = ctrl_q[0];
  assign force_blank = ctrl_q[1];
  assign idx_next    = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
  assign unused_wdata = ^bus.writedata[31:5];

  assign segs         = segs_q;
  assign digit_sel    = digit_sel_q;
  assign bus.readdata = readdata_q;

  // Hex glyphs for a common-anode display; any value with bit 4 set is blank.
  function automatic logic [6:0] hex_decode(input logic [4:0] v);
    logic [6:0] g;
    if (v[4]) begin
      g = 7'h7F;
    end else begin
      case (v[3:0])
        4'h0: g = 7'h40;
        4'h1: g = 7'h79;
        4'h2: g = 7'h24;
        4'h3: g = 7'h30;
        4'h4: g = 7'h19;
        4'h5: g = 7'h12;
        4'h6: g = 7'h02;
        4'h7: g = 7'h78;
        4'h8: g = 7'h00;
        4'h9: g = 7'h10;
        4'hA: g = 7'h08;
        4'hB: g = 7'h03;
        4'hC: g = 7'h46;
        4'hD: g = 7'h21;
        4'hE: g = 7'h06;
        default: g = 7'h0E;
      endcase
    end
    return g;
  endfunction

  // Register writes: digit values and control bits, other addresses are ignored.
  always_comb begin
    digit_d = digit_q;
    ctrl_d  = ctrl_q;
    if (bus_wr) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (bus.address == 3'(i)) begin
          digit_d[i] = bus.writedata[4:0];
        end
      end
      if (bus.address == ADDR_CTRL) begin
        ctrl_d = bus.writedata[1:0];
      end
    end
  end

  // Register reads: sampled from current state, so a same-edge write returns the old value.
  always_comb begin
    readdata_d = readdata_q;
    if (bus_rd) begin
      readdata_d = 32'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (bus.address == 3'(i)) begin
          readdata_d = {27'd0, digit_q[i]};
        end
      end
      if (bus.address == ADDR_STATUS) begin
        readdata_d = {26'd0, state_q == BLANK, state_q == ON, 1'b0, idx_q};
      end
      if (bus.address == ADDR_CTRL) begin
        readdata_d = {30'd0, ctrl_q};
      end
    end
  end

  // Scan sequencing: dwell on a digit, optional blank gap, then advance; dropping ENABLE aborts at once.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 32'd1;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = 3'd0;
      cnt_d   = 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ON;
          idx_d   = 3'd0;
          cnt_d   = 32'd0;
        end
        ON: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d = 32'd0;
            if (BLANK_CYCLES == 0) begin
              idx_d = idx_next;
            end else begin
              state_d = BLANK;
            end
          end
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ON;
            idx_d   = idx_next;
            cnt_d   = 32'd0;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = 3'd0;
          cnt_d   = 32'd0;
        end
      endcase
    end
  end

  // Value of the digit that will be lit after this edge (register contents before any same-edge write).
  always_comb begin
    lit_value = 5'h10;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == 3'(i)) begin
        lit_value = digit_q[i];
      end
    end
  end

`ifdef SEVSEG_LZ_BLANK_EN
  logic higher_clear;

  // Leading-zero suppression: a zero digit is hidden when every more-significant digit is zero or blank.
  always_comb begin
    lz_suppress  = 1'b0;
    higher_clear = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if ((idx_d == 3'(i)) && (digit_q[i] == 5'd0) && higher_clear) begin
        lz_suppress = 1'b1;
      end
      if ((digit_q[i] != 5'd0) && !digit_q[i][4]) begin
        higher_clear = 1'b0;
      end
    end
  end
`else
  assign lz_suppress = 1'b0;
`endif

  // Display outputs follow the next state/index so they switch on the same edge as the FSM.
  always_comb begin
    segs_d      = 7'h7F;
    digit_sel_d = '1;
    if (state_d == ON) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_d == 3'(i)) begin
          digit_sel_d[i] = 1'b0;
        end
      end
      if (!force_blank && !lz_suppress) begin
        segs_d = hex_decode(lit_value);
      end
    end
  end

  // State, registers and outputs; reset overrides any concurrent bus access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      cnt_q       <= 32'd0;
      ctrl_q      <= 2'd0;
      segs_q      <= 7'h7F;
      digit_sel_q <= '1;
      readdata_q  <= 32'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_q[i] <= 5'h10;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      ctrl_q      <= ctrl_d;
      segs_q      <= segs_d;
      digit_sel_q <= digit_sel_d;
      readdata_q  <= readdata_d;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_q[i] <= digit_d[i];
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - self-checking bench for seven_seg_scan_ctrl, blank and no-blank variants
module tb_seven_seg_scan_ctrl;

  localparam int N  = 4;
  localparam int DW = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] segs_a, segs_b;
  logic [3:0] sel_a, sel_b;

  seven_seg_scan_ctrl_if bus_a ();
  seven_seg_scan_ctrl_if bus_b ();

  seven_seg_scan_ctrl #(.NUM_DIGITS(N), .DWELL_CYCLES(DW), .BLANK_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .segs(segs_a), .digit_sel(sel_a)
  );

  seven_seg_scan_ctrl #(.NUM_DIGITS(N), .DWELL_CYCLES(DW), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .segs(segs_b), .digit_sel(sel_b)
  );

  always #5 clk = ~clk;

  int checks;
  int errors;

  // Reference model: cycles elapsed since the scan started (-1 when idle).
  int          blank_c [2] = '{2, 0};
  int          k [2];
  logic        en_m, fb_m;
  logic [4:0]  mdig [N];
  logic [31:0] exp_rd [2];
  logic [6:0]  exp_segs [2];
  logic [3:0]  exp_sel [2];
  logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] dec(input logic [4:0] v);
    if (v >= 5'd16) return 7'h7F;
    return hex_tab[v[3:0]];
  endfunction

  function automatic bit lz(input int id);
    bit r = 0;
`ifdef SEVSEG_LZ_BLANK_EN
    if (id > 0 && mdig[id] == 5'd0) begin
      r = 1;
      for (int j = id + 1; j < N; j++) begin
        if (mdig[j] != 5'd0 && mdig[j] < 5'd16) r = 0;
      end
    end
`endif
    return r;
  endfunction

  function automatic logic [31:0] status_of(input int m);
    logic [31:0] s = 32'd0;
    int p, pos;
    if (k[m] >= 0) begin
      p   = DW + blank_c[m];
      pos = k[m] % p;
      s[2:0] = 3'((k[m] / p) % N);
      if (pos < DW) s[4] = 1'b1;
      else          s[5] = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [31:0] reg_value(input int m, input logic [2:0] a);
    if (a < 3'(N)) return {27'd0, mdig[a[1:0]]};
    if (a == 3'd6) return status_of(m);
    if (a == 3'd7) return {30'd0, fb_m, en_m};
    return 32'd0;
  endfunction

  function automatic void set_exp(input int m);
    int p, pos, id;
    exp_segs[m] = 7'h7F;
    exp_sel[m]  = 4'hF;
    if (k[m] >= 0) begin
      p   = DW + blank_c[m];
      pos = k[m] % p;
      id  = (k[m] / p) % N;
      if (pos < DW) begin
        exp_sel[m]  = ~(4'b0001 << id);
        exp_segs[m] = (fb_m || lz(id)) ? 7'h7F : dec(mdig[id]);
      end
    end
  endfunction

  task automatic drive(input logic cs, input logic wr, input logic rd,
                       input logic [2:0] a, input logic [31:0] wd);
    bus_a.chipselect = cs; bus_a.write = wr; bus_a.read = rd; bus_a.address = a; bus_a.writedata = wd;
    bus_b.chipselect = cs; bus_b.write = wr; bus_b.read = rd; bus_b.address = a; bus_b.writedata = wd;
  endtask

  // One clock: drive, advance the model across the edge, then compare both DUTs.
  task automatic step(input logic rst, input logic cs, input logic wr, input logic rd,
                      input logic [2:0] a, input logic [31:0] wd);
    reset = rst;
    drive(cs, wr, rd, a, wd);
    @(posedge clk);
    if (rst) begin
      en_m = 1'b0;
      fb_m = 1'b0;
      for (int i = 0; i < N; i++) mdig[i] = 5'h10;
      for (int m = 0; m < 2; m++) begin
        k[m] = -1;
        exp_rd[m] = 32'd0;
        set_exp(m);
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (cs && rd) exp_rd[m] = reg_value(m, a);
      end
      for (int m = 0; m < 2; m++) begin
        k[m] = !en_m ? -1 : (k[m] < 0 ? 0 : k[m] + 1);
        set_exp(m);
      end
      if (cs && wr) begin
        if (a < 3'(N)) mdig[a[1:0]] = wd[4:0];
        else if (a == 3'd7) begin
          en_m = wd[0];
          fb_m = wd[1];
        end
      end
    end
    #1;
    chk("segs_a", {25'd0, segs_a}, {25'd0, exp_segs[0]});
    chk("sel_a", {28'd0, sel_a}, {28'd0, exp_sel[0]});
    chk("rdata_a", bus_a.readdata, exp_rd[0]);
    chk("segs_b", {25'd0, segs_b}, {25'd0, exp_segs[1]});
    chk("sel_b", {28'd0, sel_b}, {28'd0, exp_sel[1]});
    chk("rdata_b", bus_b.readdata, exp_rd[1]);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd_reg(input logic [2:0] a);
    step(1'b0, 1'b1, 1'b0, 1'b1, a, 32'd0);
  endtask

  initial begin
    int          op;
    logic [2:0]  a;
    logic [31:0] d;
    bit          found;
    logic [6:0]  lz_exp;

    checks = 0;
    errors = 0;
    en_m = 1'b0;
    fb_m = 1'b0;
    k[0] = -1;
    k[1] = -1;
    for (int i = 0; i < N; i++) mdig[i] = 5'h10;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);

    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    chk("rst_segs", {25'd0, segs_a}, 32'h7F);
    chk("rst_sel", {28'd0, sel_a}, 32'hF);
    chk("rst_rdata", bus_a.readdata, 32'd0);

    wr_reg(3'd0, 32'd0);
    wr_reg(3'd1, 32'd1);
    wr_reg(3'd2, 32'd2);
    wr_reg(3'd3, 32'd3);
    rd_reg(3'd3);
    chk("dig3_rd", bus_a.readdata, 32'd3);
    wr_reg(3'd7, 32'd1);
    idle();
    chk("first_on_sel", {28'd0, sel_a}, 32'hE);
    chk("first_on_segs", {25'd0, segs_a}, 32'h40);
    repeat (3) idle();
    idle();
    chk("blank_sel", {28'd0, sel_a}, 32'hF);
    chk("blank_segs", {25'd0, segs_a}, 32'h7F);
    chk("noblank_sel_b", {28'd0, sel_b}, 32'hD);
    idle();
    idle();
    chk("idx1_sel", {28'd0, sel_a}, 32'hD);
    chk("idx1_segs", {25'd0, segs_a}, 32'h79);
    wr_reg(3'd1, 32'hA);
    chk("live_wr_old", {25'd0, segs_a}, 32'h79);
    idle();
    chk("live_wr_new", {25'd0, segs_a}, 32'h08);
    for (int n = 0; n < 15; n++) begin
      idle();
      chk("b_never_off", {31'd0, sel_b != 4'hF}, 32'd1);
    end
    idle();
    chk("wrap_sel", {28'd0, sel_a}, 32'hE);

    wr_reg(3'd5, 32'h1F);
    rd_reg(3'd5);
    chk("addr5_rd", bus_a.readdata, 32'd0);

    found = 0;
    for (int n = 0; n < 64; n++) begin
      if (k[0] >= 0 && k[0] % 24 == 12) begin
        found = 1;
        break;
      end
      idle();
    end
    chk("seek_idx2", {31'd0, found}, 32'd1);
    wr_reg(3'd7, 32'd0);
    chk("pre_dis_sel", {28'd0, sel_a}, 32'hB);
    idle();
    chk("dis_sel", {28'd0, sel_a}, 32'hF);
    chk("dis_segs", {25'd0, segs_a}, 32'h7F);
    rd_reg(3'd6);
    chk("dis_status", bus_a.readdata, 32'd0);

    wr_reg(3'd7, 32'd1);
    for (int n = 0; n < 4; n++) begin
      idle();
      chk("reen_dwell", {28'd0, sel_a}, 32'hE);
    end
    idle();
    chk("reen_blank", {28'd0, sel_a}, 32'hF);

    wr_reg(3'd7, 32'd3);
    idle();
    for (int n = 0; n < 24; n++) begin
      idle();
      chk("fb_segs", {25'd0, segs_a}, 32'h7F);
    end
    wr_reg(3'd7, 32'd1);

    for (int n = 0; n < 300; n++) begin
      op = int'($urandom_range(0, 9));
      a  = 3'($urandom_range(0, 7));
      d  = $urandom;
      if (a == 3'd7) d[0] = ($urandom_range(0, 4) != 0);
      case (op)
        4:       wr_reg(3'($urandom_range(0, 3)), d);
        5:       wr_reg(a, d);
        6, 7, 8: rd_reg(a);
        9:       step(1'b0, 1'b1, 1'b1, 1'b1, a, d);
        default: idle();
      endcase
    end

    wr_reg(3'd7, 32'd1);
    found = 0;
    for (int n = 0; n < 64; n++) begin
      if (k[0] >= 0 && k[0] % 6 < 3) begin
        found = 1;
        break;
      end
      idle();
    end
    chk("seek_on", {31'd0, found}, 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 32'd5);
    step(1'b1, 1'b1, 1'b0, 1'b1, 3'd7, 32'd0);
    chk("midrst_segs", {25'd0, segs_a}, 32'h7F);
    chk("midrst_sel", {28'd0, sel_a}, 32'hF);
    idle();
    chk("midrst_idle_sel", {28'd0, sel_a}, 32'hF);
    rd_reg(3'd6);
    chk("midrst_status", bus_a.readdata, 32'd0);
    rd_reg(3'd0);
    chk("midrst_dig0", bus_a.readdata, 32'h10);

`ifdef SEVSEG_LZ_BLANK_EN
    lz_exp = 7'h7F;
`else
    lz_exp = 7'h40;
`endif
    wr_reg(3'd0, 32'd0);
    wr_reg(3'd1, 32'd0);
    wr_reg(3'd2, 32'd5);
    wr_reg(3'd3, 32'd0);
    wr_reg(3'd7, 32'd1);
    for (int n = 0; n < 19; n++) begin
      idle();
      if (k[0] == 0)  chk("lz_idx0", {25'd0, segs_a}, 32'h40);
      if (k[0] == 6)  chk("lz_idx1", {25'd0, segs_a}, 32'h40);
      if (k[0] == 12) chk("lz_idx2", {25'd0, segs_a}, 32'h12);
      if (k[0] == 18) chk("lz_idx3", {25'd0, segs_a}, {25'd0, lz_exp});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
